// File: rtl/csrng_health_pkg.sv
// Shared types and constants for the CSRNG health monitor.
// Optional feature macro: CSRNG_HEALTH_BLOCK_EN (see csrng_health_mon).
package csrng_health_pkg;

  // Width of one CSRNG output word
  localparam int GENBITS_W = 128;

  // Health monitor state: RUN while healthy, ALERT after any failure
  typedef enum logic {
    RUN   = 1'b0,
    ALERT = 1'b1
  } hm_state_e;

  // Bit positions inside alert_cause
  localparam int CAUSE_REP  = 0;
  localparam int CAUSE_PROP = 1;

  // 8-bit increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/csrng_popcount128.sv
// Combinational population count of one 128-bit CSRNG word.
// Counts ones per byte, then adds the sixteen byte counts.
module csrng_popcount128
  import csrng_health_pkg::*;
(
  input  logic [GENBITS_W-1:0] bits_i,
  output logic [7:0]           cnt_o
);

  localparam int NBYTES = GENBITS_W / 8;

  logic [3:0] byte_cnt [NBYTES];

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
    assign byte_cnt[gi] = 4'($countones(bits_i[gi*8 +: 8]));
  end

  // Sum the per-byte counts; 128 still fits in 8 bits
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < NBYTES; i++) begin
      cnt_o = cnt_o + {4'b0, byte_cnt[i]};
    end
  end

endmodule

// File: rtl/csrng_health_mon.sv
// CSRNG health monitor: one-entry forwarding register plus a repetition
// test and a windowed proportion (ones count) test with a sticky alert.
// Define CSRNG_HEALTH_BLOCK_EN to drop words (instead of forwarding them)
// while the monitor is in ALERT, including the failing word itself.
module csrng_health_mon
  import csrng_health_pkg::*;
#(
  parameter int REP_THRESH   = 4,
  parameter int WINDOW_WORDS = 16,
  parameter int ONES_LO      = 896,
  parameter int ONES_HI      = 1152
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [GENBITS_W-1:0] genbits,
  input  logic                 genbits_valid,
  output logic                 genbits_ready,
  output logic [GENBITS_W-1:0] out_bits,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 alert_clr,
  output logic                 alert,
  output logic [1:0]           alert_cause,
  output logic [7:0]           fail_cnt
);

  // Width-matched copies of the thresholds
  localparam logic [7:0]  REP_THRESH_W = 8'(REP_THRESH);
  localparam logic [5:0]  WIN_LAST     = 6'(WINDOW_WORDS - 1);
  // Final window sum can reach 64*128 = 8192, one bit past the accumulator
  localparam logic [13:0] ONES_LO_W    = 14'(ONES_LO);
  localparam logic [13:0] ONES_HI_W    = 14'(ONES_HI);

  // Output register
  logic [GENBITS_W-1:0] out_bits_q, out_bits_d;
  logic                 out_valid_q, out_valid_d;

  // Repetition test state
  logic [GENBITS_W-1:0] prev_q, prev_d;
  logic                 prev_vld_q, prev_vld_d;
  logic [7:0]           rep_cnt_q, rep_cnt_d;

  // Proportion test state
  logic [12:0]          acc_q, acc_d;
  logic [5:0]           wcnt_q, wcnt_d;
  logic [13:0]          win_sum;

  // Alert bookkeeping
  hm_state_e            state_q, state_d;
  logic [1:0]           cause_q, cause_d;
  logic [7:0]           fail_cnt_q, fail_cnt_d;

  logic                 accept;
  logic                 rep_fail;
  logic                 prop_fail;
  logic                 any_fail;
  logic                 fwd_en;
  logic [7:0]           pop_cnt;

  csrng_popcount128 u_popcount (
    .bits_i (genbits),
    .cnt_o  (pop_cnt)
  );

  // Ready whenever the output slot is empty or is being drained this cycle
  assign genbits_ready = !out_valid_q || out_ready;
  assign accept        = genbits_valid && genbits_ready;
  assign any_fail      = rep_fail || prop_fail;

`ifdef CSRNG_HEALTH_BLOCK_EN
  // Only healthy words seen in RUN make it downstream
  assign fwd_en = (state_q == RUN) && !any_fail;
`else
  // Monitoring only: every accepted word is forwarded
  assign fwd_en = 1'b1;
`endif

  // Repetition and proportion tests evaluated on each accepted word
  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    rep_cnt_d  = rep_cnt_q;
    acc_d      = acc_q;
    wcnt_d     = wcnt_q;
    rep_fail   = 1'b0;
    prop_fail  = 1'b0;
    win_sum    = {1'b0, acc_q} + {6'b0, pop_cnt};
    if (accept) begin
      prev_d     = genbits;
      prev_vld_d = 1'b1;
      if (prev_vld_q && (genbits == prev_q)) begin
        rep_cnt_d = sat_inc8(rep_cnt_q);
      end else begin
        rep_cnt_d = 8'd1;
      end
      // Fires at the threshold and keeps firing on every further repeat
      rep_fail = (rep_cnt_d >= REP_THRESH_W);
      if (wcnt_q == WIN_LAST) begin
        prop_fail = (win_sum < ONES_LO_W) || (win_sum > ONES_HI_W);
        acc_d     = '0;
        wcnt_d    = '0;
      end else begin
        acc_d  = win_sum[12:0];
        wcnt_d = wcnt_q + 6'd1;
      end
    end
  end

  // Output slot: load on forwarded accept, empty when drained
  always_comb begin
    out_bits_d  = out_bits_q;
    out_valid_d = out_valid_q;
    if (accept && fwd_en) begin
      out_bits_d  = genbits;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Next state: a failure always wins over a clear in the same cycle
  always_comb begin
    state_d = state_q;
    if (any_fail) begin
      state_d = ALERT;
    end else if ((state_q == ALERT) && alert_clr) begin
      state_d = RUN;
    end
  end

  // Sticky cause bits and saturating failure counter
  always_comb begin
    cause_d    = cause_q;
    fail_cnt_d = fail_cnt_q;
    if (any_fail) begin
      // A simultaneous clear wipes the old causes, leaving only the new one
      cause_d             = alert_clr ? 2'b00 : cause_q;
      cause_d[CAUSE_REP]  = cause_d[CAUSE_REP]  | rep_fail;
      cause_d[CAUSE_PROP] = cause_d[CAUSE_PROP] | prop_fail;
      fail_cnt_d          = sat_inc8(fail_cnt_q);
    end else if (alert_clr) begin
      cause_d = 2'b00;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Data path and test registers; reset discards any partial window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_bits_q  <= '0;
      out_valid_q <= 1'b0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      rep_cnt_q   <= '0;
      acc_q       <= '0;
      wcnt_q      <= '0;
      cause_q     <= '0;
      fail_cnt_q  <= '0;
    end else begin
      out_bits_q  <= out_bits_d;
      out_valid_q <= out_valid_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      rep_cnt_q   <= rep_cnt_d;
      acc_q       <= acc_d;
      wcnt_q      <= wcnt_d;
      cause_q     <= cause_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    alert       = (state_q == ALERT);
    alert_cause = cause_q;
    fail_cnt    = fail_cnt_q;
    out_bits    = out_bits_q;
    out_valid   = out_valid_q;
  end

endmodule
